// File: rtl/multi_signal_holder.sv
`default_nettype none
// ============================================================================
// Module      : multi_signal_holder
// Description : Multi-channel pulse stretcher. Each channel turns a short
//               event into a level held high for HOLD_TIME+1 clk cycles. It
//               supports a shared retrigger mode, edge or level triggering,
//               and a per-channel clear.
// Revision    : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   CHANNELS   number of independent channels (>=1)
//   HOLD_TIME  extra cycles the output stays high after the last accepted
//              trigger (>=0)
//   EDGE_TRIG  0: trigger on the level of signal_in
//              1: trigger only on a 0->1 transition of signal_in
// Ports
//   clk         in   1         rising-edge clock
//   rst         in   1         synchronous reset, active-high
//   signal_in   in   CHANNELS  event inputs
//   retrigger   in   1         1: triggers during a hold reload the counter
//   clear       in   CHANNELS  per-channel abort of an active hold
//   signal_out  out  CHANNELS  stretched outputs (registered)
//   busy        out  1         OR of all signal_out bits (registered)
//   expired     out  CHANNELS  only when HOLDER_EXPIRED_EN is defined:
//                              one-cycle pulse when a hold runs out naturally
// Optional feature macro: HOLDER_EXPIRED_EN
// ============================================================================
module multi_signal_holder #(
  parameter int CHANNELS  = 4,
  parameter int HOLD_TIME = 16,
  parameter int EDGE_TRIG = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [CHANNELS-1:0] signal_in,
  input  logic                retrigger,
  input  logic [CHANNELS-1:0] clear,
  output logic [CHANNELS-1:0] signal_out,
  output logic                busy
`ifdef HOLDER_EXPIRED_EN
  ,
  output logic [CHANNELS-1:0] expired
`endif
);

  // $clog2(1) is 0, so HOLD_TIME=0 still needs a 1-bit counter.
  localparam int               CNT_W       = (HOLD_TIME > 0) ? $clog2(HOLD_TIME + 1) : 1;
  localparam logic [CNT_W-1:0] C_HOLD_LOAD = CNT_W'(HOLD_TIME);
  localparam logic [CNT_W-1:0] C_ONE       = CNT_W'(1);

  logic [CHANNELS-1:0] w_out_all;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    logic             w_trig;
    logic             w_accept;
    logic             w_out_next;
    logic [CNT_W-1:0] w_cnt_next;
    logic [CNT_W-1:0] r_cnt;
    logic             r_out;

    if (EDGE_TRIG != 0) begin : g_edge
      // The edge history follows the input every cycle, even while the
      // channel is being cleared, so a clear cannot fake a fresh edge.
      logic r_prev;
      always_ff @(posedge clk) begin
        if (rst) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= signal_in[i];
        end
      end
      assign w_trig = signal_in[i] & ~r_prev;
    end else begin : g_level
      assign w_trig = signal_in[i];
    end

    // A trigger that arrives during a hold only takes effect in retrigger mode.
    assign w_accept = w_trig & (~r_out | retrigger);

    // Priority: clear > accepted trigger > count-down > idle.
    always_comb begin
      w_cnt_next = r_cnt;
      w_out_next = 1'b0;
      if (clear[i]) begin
        w_cnt_next = '0;
      end else if (w_accept) begin
        w_cnt_next = C_HOLD_LOAD;
        w_out_next = 1'b1;
      end else if (r_cnt != '0) begin
        w_cnt_next = r_cnt - C_ONE;
        w_out_next = 1'b1;
      end
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        r_cnt <= '0;
        r_out <= 1'b0;
      end else begin
        r_cnt <= w_cnt_next;
        r_out <= w_out_next;
      end
    end

    assign signal_out[i] = r_out;
    assign w_out_all[i]  = w_out_next;

`ifdef HOLDER_EXPIRED_EN
    // A natural expiry is the cycle where the output is high, the count is
    // exhausted, and neither a clear nor a new accepted trigger intervenes.
    logic r_exp;
    always_ff @(posedge clk) begin
      if (rst) begin
        r_exp <= 1'b0;
      end else begin
        r_exp <= r_out & ~clear[i] & ~w_accept & (r_cnt == '0);
      end
    end
    assign expired[i] = r_exp;
`endif
  end

  // busy is computed from the next-state outputs so that it rises and falls
  // in the same cycle as signal_out.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy <= 1'b0;
    end else begin
      busy <= |w_out_all;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_signal_holder.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_signal_holder
// Description : Self-checking bench for multi_signal_holder. Five instances
//               with different configurations share one stimulus stream and
//               are compared every cycle against a behavioural model. The
//               bench also includes a vector table, directed corner-case
//               sequences, and a randomized phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_signal_holder;

  localparam int NI = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic       retrig;
  logic [3:0] sig;
  logic [3:0] clr;

  logic [3:0] out_a, out_d;
  logic [0:0] out_b, out_e;
  logic [1:0] out_c;
  logic       busy_a, busy_b, busy_c, busy_d, busy_e;
`ifdef HOLDER_EXPIRED_EN
  logic [3:0] exp_a, exp_d;
  logic [0:0] exp_b, exp_e;
  logic [1:0] exp_c;
`endif

  always #5 clk = ~clk;

  // a: 4ch hold 4 level | b: 1ch hold 0 | c: 2ch hold 2 edge
  // d: 4ch hold 8 level | e: 1ch hold 2 level
  multi_signal_holder #(.CHANNELS(4), .HOLD_TIME(4), .EDGE_TRIG(0)) dut_a (
    .clk(clk), .rst(rst), .signal_in(sig), .retrigger(retrig), .clear(clr),
    .signal_out(out_a), .busy(busy_a)
`ifdef HOLDER_EXPIRED_EN
    , .expired(exp_a)
`endif
  );
  multi_signal_holder #(.CHANNELS(1), .HOLD_TIME(0), .EDGE_TRIG(0)) dut_b (
    .clk(clk), .rst(rst), .signal_in(sig[0:0]), .retrigger(retrig), .clear(clr[0:0]),
    .signal_out(out_b), .busy(busy_b)
`ifdef HOLDER_EXPIRED_EN
    , .expired(exp_b)
`endif
  );
  multi_signal_holder #(.CHANNELS(2), .HOLD_TIME(2), .EDGE_TRIG(1)) dut_c (
    .clk(clk), .rst(rst), .signal_in(sig[1:0]), .retrigger(retrig), .clear(clr[1:0]),
    .signal_out(out_c), .busy(busy_c)
`ifdef HOLDER_EXPIRED_EN
    , .expired(exp_c)
`endif
  );
  multi_signal_holder #(.CHANNELS(4), .HOLD_TIME(8), .EDGE_TRIG(0)) dut_d (
    .clk(clk), .rst(rst), .signal_in(sig), .retrigger(retrig), .clear(clr),
    .signal_out(out_d), .busy(busy_d)
`ifdef HOLDER_EXPIRED_EN
    , .expired(exp_d)
`endif
  );
  multi_signal_holder #(.CHANNELS(1), .HOLD_TIME(2), .EDGE_TRIG(0)) dut_e (
    .clk(clk), .rst(rst), .signal_in(sig[0:0]), .retrigger(retrig), .clear(clr[0:0]),
    .signal_out(out_e), .busy(busy_e)
`ifdef HOLDER_EXPIRED_EN
    , .expired(exp_e)
`endif
  );

  // ---------------- instance configuration lookup ----------------
  function automatic int ch_of(input int j);
    case (j)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 4;
      default: return 1;
    endcase
  endfunction

  function automatic int hold_of(input int j);
    case (j)
      0: return 4;
      1: return 0;
      2: return 2;
      3: return 8;
      default: return 2;
    endcase
  endfunction

  function automatic bit edge_of(input int j);
    return (j == 2);
  endfunction

  function automatic logic [3:0] dut_out(input int j);
    case (j)
      0: return out_a;
      1: return {3'b000, out_b};
      2: return {2'b00, out_c};
      3: return out_d;
      default: return {3'b000, out_e};
    endcase
  endfunction

  function automatic logic dut_busy(input int j);
    case (j)
      0: return busy_a;
      1: return busy_b;
      2: return busy_c;
      3: return busy_d;
      default: return busy_e;
    endcase
  endfunction

`ifdef HOLDER_EXPIRED_EN
  function automatic logic [3:0] dut_exp(input int j);
    case (j)
      0: return exp_a;
      1: return {3'b000, exp_b};
      2: return {2'b00, exp_c};
      3: return exp_d;
      default: return {3'b000, exp_e};
    endcase
  endfunction
`endif

  // ---------------- behavioural model ----------------
  // left[j][i]: number of further cycles the output remains high after the
  // current one. high[j][i]: the output level in the current cycle.
  int n_cmp = 0;
  int n_bad = 0;
  int left  [NI][4];
  bit high  [NI][4];
  bit prev  [NI][4];
  bit fell  [NI][4];

  task automatic model_step();
    for (int j = 0; j < NI; j++) begin
      for (int i = 0; i < ch_of(j); i++) begin
        bit t;
        if (rst) begin
          left[j][i] = 0; high[j][i] = 0; prev[j][i] = 0; fell[j][i] = 0;
        end else begin
          t = edge_of(j) ? (sig[i] && !prev[j][i]) : sig[i];
          fell[j][i] = 0;
          if (clr[i]) begin
            left[j][i] = 0; high[j][i] = 0;
          end else if (t && (!high[j][i] || retrig)) begin
            left[j][i] = hold_of(j); high[j][i] = 1;
          end else if (left[j][i] > 0) begin
            left[j][i]--; high[j][i] = 1;
          end else begin
            fell[j][i] = high[j][i];
            high[j][i] = 0;
          end
          prev[j][i] = sig[i];
        end
      end
    end
  endtask

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic compare_model();
    for (int j = 0; j < NI; j++) begin
      logic [3:0] eo, ee;
      eo = '0; ee = '0;
      for (int i = 0; i < ch_of(j); i++) begin
        eo[i] = high[j][i];
        ee[i] = fell[j][i];
      end
      check($sformatf("model_out[%0d]", j), dut_out(j), eo);
      check($sformatf("model_busy[%0d]", j), {3'b000, dut_busy(j)}, {3'b000, |eo});
`ifdef HOLDER_EXPIRED_EN
      check($sformatf("model_expired[%0d]", j), dut_exp(j), ee);
`endif
    end
  endtask

  // Drive inputs, clock one edge, advance the model, and check on the falling edge.
  task automatic step(input bit r, input bit rt, input logic [3:0] s, input logic [3:0] c);
    rst = r; retrig = rt; sig = s; clr = c;
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_model();
  endtask

  // ---------------- directed vector table (expectations for dut_a) ----------------
  typedef struct {
    bit         r;
    bit         rt;
    logic [3:0] s;
    logic [3:0] c;
    logic [3:0] eout;
    bit         ebusy;
  } vec_t;

  vec_t tbl[30];

  function automatic vec_t mk(input bit r, input bit rt, input logic [3:0] s,
                              input logic [3:0] c, input logic [3:0] eo, input bit eb);
    vec_t v;
    v.r = r; v.rt = rt; v.s = s; v.c = c; v.eout = eo; v.ebusy = eb;
    return v;
  endfunction

  initial begin
    int hi_b, hi_c, hi_e, cnt_x;
    rst = 1'b1; retrig = 1'b0; sig = '0; clr = '0;

    tbl[0]  = mk(1, 0, 4'h0, 4'h0, 4'h0, 0);  // reset state
    tbl[1]  = mk(0, 0, 4'h1, 4'h0, 4'h1, 1);  // ch0 single pulse: 5 high cycles
    tbl[2]  = mk(0, 0, 4'h0, 4'h0, 4'h1, 1);
    tbl[3]  = mk(0, 0, 4'h0, 4'h0, 4'h1, 1);
    tbl[4]  = mk(0, 0, 4'h0, 4'h0, 4'h1, 1);
    tbl[5]  = mk(0, 0, 4'h0, 4'h0, 4'h1, 1);
    tbl[6]  = mk(0, 0, 4'h0, 4'h0, 4'h0, 0);
    tbl[7]  = mk(0, 1, 4'h2, 4'h0, 4'h2, 1);  // ch1 retrigger: pulses 3 apart -> 8 high
    tbl[8]  = mk(0, 1, 4'h0, 4'h0, 4'h2, 1);
    tbl[9]  = mk(0, 1, 4'h0, 4'h0, 4'h2, 1);
    tbl[10] = mk(0, 1, 4'h2, 4'h0, 4'h2, 1);
    tbl[11] = mk(0, 1, 4'h0, 4'h0, 4'h2, 1);
    tbl[12] = mk(0, 1, 4'h0, 4'h0, 4'h2, 1);
    tbl[13] = mk(0, 1, 4'h0, 4'h0, 4'h2, 1);
    tbl[14] = mk(0, 1, 4'h0, 4'h0, 4'h2, 1);
    tbl[15] = mk(0, 1, 4'h0, 4'h0, 4'h0, 0);
    tbl[16] = mk(0, 0, 4'h4, 4'h0, 4'h4, 1);  // ch2 no retrigger: second pulse ignored
    tbl[17] = mk(0, 0, 4'h0, 4'h0, 4'h4, 1);
    tbl[18] = mk(0, 0, 4'h0, 4'h0, 4'h4, 1);
    tbl[19] = mk(0, 0, 4'h4, 4'h0, 4'h4, 1);
    tbl[20] = mk(0, 0, 4'h0, 4'h0, 4'h4, 1);
    tbl[21] = mk(0, 0, 4'h0, 4'h0, 4'h0, 0);
    tbl[22] = mk(0, 0, 4'h8, 4'h0, 4'h8, 1);  // ch3 clear beats a same-cycle trigger
    tbl[23] = mk(0, 0, 4'h0, 4'h0, 4'h8, 1);
    tbl[24] = mk(0, 0, 4'h8, 4'h8, 4'h0, 0);
    tbl[25] = mk(0, 0, 4'h0, 4'h0, 4'h0, 0);
    tbl[26] = mk(0, 0, 4'hF, 4'h0, 4'hF, 1);  // all channels, partial clear, then reset
    tbl[27] = mk(0, 0, 4'h0, 4'h3, 4'hC, 1);
    tbl[28] = mk(1, 0, 4'hF, 4'h0, 4'h0, 0);
    tbl[29] = mk(0, 0, 4'h0, 4'h0, 4'h0, 0);

    @(negedge clk);
    for (int k = 0; k < 30; k++) begin
      step(tbl[k].r, tbl[k].rt, tbl[k].s, tbl[k].c);
      check($sformatf("tbl_out[%0d]", k), out_a, tbl[k].eout);
      check($sformatf("tbl_busy[%0d]", k), {3'b000, busy_a}, {3'b000, tbl[k].ebusy});
    end

    // HOLD_TIME=0: a one-cycle pulse appears one clock later, for one cycle.
    for (int k = 0; k < 3; k++) step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h1, 4'h0);
    check("h0_first", {3'b000, out_b}, 4'h1);
    hi_b = 1;
    for (int k = 0; k < 4; k++) begin
      step(0, 0, 4'h0, 4'h0);
      hi_b += int'(out_b);
    end
    check("h0_width", 4'(hi_b), 4'd1);

    // Input held high for 10 cycles: edge mode gives 3 cycles, level+retrigger gives 12.
    for (int k = 0; k < 4; k++) step(0, 0, 4'h0, 4'h0);
    hi_c = 0; hi_e = 0;
    for (int k = 0; k < 16; k++) begin
      step(0, 1, (k < 10) ? 4'h1 : 4'h0, 4'h0);
      hi_c += int'(out_c[0]);
      hi_e += int'(out_e);
    end
    check("edge_width", 4'(hi_c), 4'd3);
    check("level_width", 4'(hi_e), 4'd12);

    // HOLD_TIME=8: a clear with a same-cycle trigger mid-hold, then a reset mid-hold.
    for (int k = 0; k < 10; k++) step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h4, 4'h0);
    check("clr_start", out_d, 4'h4);
    step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h0, 4'h0);
    step(0, 0, 4'h4, 4'h4);
    check("clr_drop", out_d, 4'h0);
    for (int k = 0; k < 3; k++) begin
      step(0, 0, 4'h0, 4'h0);
      check("clr_stay", out_d, 4'h0);
    end
    step(0, 0, 4'hF, 4'h0);
    step(0, 0, 4'h0, 4'h0);
    check("rst_pre", out_d, 4'hF);
    step(1, 0, 4'h0, 4'h0);
    check("rst_out_d", out_d, 4'h0);
    check("rst_busy_d", {3'b000, busy_d}, 4'h0);
    step(0, 0, 4'h0, 4'h0);
    check("rst_after", out_d, 4'h0);

`ifdef HOLDER_EXPIRED_EN
    // The expired pulse fires once on a natural end of a hold and never on a clear.
    for (int k = 0; k < 10; k++) step(0, 0, 4'h0, 4'h0);
    cnt_x = 0;
    step(0, 0, 4'h1, 4'h0);
    for (int k = 0; k < 6; k++) begin
      step(0, 0, 4'h0, 4'h0);
      cnt_x += int'(exp_e);
    end
    check("exp_natural", 4'(cnt_x), 4'd1);
    cnt_x = 0;
    step(0, 0, 4'h1, 4'h0);
    step(0, 0, 4'h0, 4'h1);
    for (int k = 0; k < 5; k++) begin
      step(0, 0, 4'h0, 4'h0);
      cnt_x += int'(exp_e);
    end
    check("exp_cleared", 4'(cnt_x), 4'd0);
`else
    cnt_x = 0;
`endif

    // Randomized phase; the model checks every instance every cycle.
    for (int k = 0; k < 3000; k++) begin
      logic [3:0] s, c;
      for (int b = 0; b < 4; b++) begin
        s[b] = ($urandom_range(0, 3) == 0);
        c[b] = ($urandom_range(0, 15) == 0);
      end
      step($urandom_range(0, 99) == 0, 1'($urandom_range(0, 1)), s, c);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
